irq_request_latch8: RTL

- Upstream stage of the 8-to-3 priority encoder.
- Captures eight raw request lines into a pending register and applies a per-line enable mask.
- Presents the masked pending vector to the priority encoder and takes the encoder's 3-bit index back.
- Runs a small interrupt handshake: request, acknowledge, end-of-interrupt. On acknowledge it clears the served pending bit.

---
 rtl/irq_request_latch8.sv | 96 +++++++++
 1 files changed

// File: rtl/irq_request_latch8.sv
// Request capture, enable masking and request/ack/end-of-interrupt handshake
// sitting in front of an external 8-to-3 priority encoder.
module irq_request_latch8 #(
    parameter bit          EDGE_MODE    = 1'b1,
    parameter logic [7:0]  ENABLE_RESET = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       mask_we,
    input  logic [7:0] mask_in,
    output logic [7:0] mask_out,
    output logic [7:0] to_enc,
    input  logic [2:0] enc_idx,
    output logic       irq,
    output logic [2:0] vec,
    input  logic       ack,
    input  logic       eoi,
    output logic       in_service,
    output logic [7:0] overrun,
    input  logic       ovr_clr
);

    // state   | meaning
    // IDLE    | nothing presented; latch encoder index when to_enc != 0
    // PEND    | irq high, vec frozen, waiting for ack
    // SERVICE | acknowledged line being serviced, waiting for eoi
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PEND    = 2'd1;
    localparam logic [1:0] SERVICE = 2'd2;

    logic [1:0] state;
    logic [7:0] req_q;
    logic [7:0] pending;
    logic [7:0] mask;
    logic [7:0] set;
    logic [7:0] clr;

    always_comb begin
        set = EDGE_MODE ? (req & ~req_q) : req;
        clr = 8'h00;
        if (state == PEND && ack) begin
            clr = 8'h01 << vec;
        end
    end

    assign to_enc     = pending & mask;
    assign mask_out   = mask;
    assign irq        = (state == PEND);
    assign in_service = (state == SERVICE);

    // A set on the bit being cleared wins, so the new event is not lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q   <= 8'h00;
            pending <= 8'h00;
            mask    <= ENABLE_RESET;
            overrun <= 8'h00;
        end else begin
            req_q   <= req;
            pending <= (pending & ~clr) | set;
            if (mask_we) begin
                mask <= mask_in;
            end
            overrun <= (ovr_clr ? 8'h00 : overrun) | (set & pending & ~clr);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            vec   <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (to_enc != 8'h00) begin
                        vec   <= enc_idx;
                        state <= PEND;
                    end
                end
                PEND: begin
                    if (ack) begin
                        state <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (eoi) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
